line_interpolator: RTL and testbench
====================================

LINE_INTERPOLATOR -- requirements
Module: line_interpolator

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the command queue depth (power of 2).
REQ-002 SHALL have parameter PERIOD_W, default 16, giving the step-period register width.
REQ-003 SHALL have ports PCLK in 1 clock and PRESERN in 1 reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have APB3 ports PSEL, PENABLE, PWRITE in 1 each; PADDR in 32; PWDATA in 32; PRDATA out 32; PREADY out 1 (tied 1); PSLVERR out 1 (tied 0).
REQ-005 SHALL have step_req1 and step_req2 out 1 each: one-cycle strobes that feed the stepper pulse stage.
REQ-006 SHALL have dir1 and dir2 out 1 each: direction, 1 = negative delta.
REQ-007 SHALL have done out 1: one-cycle pulse when a move completes with the queue empty.

Function
REQ-008 SHALL register an APB write only on PSEL&PENABLE&PWRITE; reads are combinational on PADDR[4:2].
REQ-009 SHALL decode registers: 0x00 DX (signed 16); 0x04 DY (signed 16); 0x08 PERIOD (R/W); 0x0C CTRL (W: bit0 push {DX,DY}, bit1 abort, bit2 clear ovf); 0x10 STATUS (R: bit0 busy, bit1 full, bit2 ovf, [7:4] count).
REQ-010 SHALL, on a push with the queue full, drop the command and set ovf sticky until cleared via CTRL bit2.
REQ-011 SHALL implement FSM IDLE->LOAD when the queue is non-empty; LOAD->RUN; RUN->LOAD or IDLE when remaining steps reach 0.
REQ-012 SHALL, in LOAD, pop one entry, set dir from the signs, and compute major=max(|dx|,|dy|), minor=min, err=major>>1, remaining=major, tick counter=0.
REQ-013 SHALL take the x axis as major when |dx|>=|dy| (tie goes to x).
REQ-014 SHALL, in RUN, fire a tick when the counter reaches eff_period-1, where eff_period=max(PERIOD,2); the counter otherwise increments.
REQ-015 SHALL, on each tick, strobe the major-axis step_req; with e=err+minor (17-bit), if e>=major strobe the minor axis and set err=e-major, else err=e; decrement remaining.
REQ-016 SHALL, on a zero-length command (dx=dy=0), go LOAD->IDLE or LOAD->LOAD with no strobes; done rules still apply.
REQ-017 SHALL handle |-32768| as 32768 without overflow, using 17-bit magnitudes.
REQ-018 SHALL, on abort, flush the queue, enter IDLE next cycle, emit no further strobes, and not pulse done.
REQ-019 SHALL hold dir stable from LOAD through the last strobe of the move, giving setup of at least eff_period-1 cycles.
REQ-020 SHALL latch a PERIOD write mid-move and apply it from the next tick onward.
REQ-021 SHALL, on a simultaneous push and pop, succeed with the count unchanged; a push on that cycle is not flagged ovf.

Reset
REQ-022 SHALL, while PRESERN is low, force step_req*=0, dir*=0, done=0, FSM=IDLE, queue empty, ovf=0, PERIOD=1000, DX=DY=0.

Configuration
REQ-023 SHALL, with LINE_INTERP_IRQ_EN defined, pulse done as in REQ-007.
REQ-024 SHALL, without LINE_INTERP_IRQ_EN, tie done to 0 and omit its logic; STATUS is unaffected.

Structure
REQ-025 SHALL place register offsets, CTRL/STATUS bit indices, the FSM state enum, and the PERIOD reset value in shared package stepper_pkg.
REQ-026 SHALL implement the queue as sub-module cmd_fifo (DEPTH x 32, push/pop/full/empty/count).

Verification
REQ-027 SHALL verify: DX=4, DY=2, PERIOD=10, push -> 4 step_req1 strobes 10 cycles apart, step_req2 with the 1st and 3rd, dir1=dir2=0, then one done.
REQ-028 SHALL verify: DX=-3, DY=5, PERIOD=2 -> dir1=1, 5 step_req2 strobes 2 cycles apart, 3 step_req1 strobes, total 5 ticks.
REQ-029 SHALL verify: 5 pushes with DEPTH=4 while busy -> STATUS full=1 and ovf=1, 5th command never executed, ovf cleared by CTRL=4.
REQ-030 SHALL verify: abort after the 2nd tick of a DX=100 move with 2 queued -> no strobes after the abort, STATUS count=0 and busy=0, done=0.
REQ-031 SHALL verify: PRESERN asserted mid-move asynchronously -> strobes stop immediately, all outputs 0, PERIOD reads 1000.
REQ-032 SHALL verify: push (0,0) then (1,1) -> no strobes for the first, one simultaneous step_req1 and step_req2, single done.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the line interpolator: APB register word indices
// (PADDR[4:2]), CTRL/STATUS bit positions, the sequencer state type, the
// PERIOD reset value and a 17-bit magnitude helper.
package stepper_pkg;

  // Register word indices; byte offsets are 0x00, 0x04, 0x08, 0x0C, 0x10.
  localparam logic [2:0] REG_DX     = 3'd0;
  localparam logic [2:0] REG_DY     = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // CTRL write bits.
  localparam int CTRL_PUSH    = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLR_OVF = 2;

  // STATUS read bits; the queue count occupies [7:4].
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;

  localparam int PERIOD_RST = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  // |v| as 17 bits, so -32768 becomes 32768 instead of overflowing.
  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] s;
    s = {v[15], v};
    return v[15] ? (~s + 17'd1) : s;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH x WIDTH synchronous FIFO with first-word fall-through.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, flush
// (drops everything, wins over push/pop), full, empty, count (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/line_interpolator.sv
// Two-axis Bresenham line interpolator with an APB3 register interface.
// Ports: PCLK, PRESERN (async active-low); APB3 PSEL/PENABLE/PWRITE/PADDR/
// PWDATA/PRDATA/PREADY/PSLVERR; step_req1/step_req2 one-cycle step strobes;
// dir1/dir2 direction (1 = negative); done one-cycle move-complete pulse.
// Commands {DX,DY} are queued in cmd_fifo and executed one after another,
// one tick every max(PERIOD,2) cycles.
// Build option: define LINE_INTERP_IRQ_EN to generate done; otherwise done
// is tied low.
module line_interpolator
  import stepper_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PERIOD_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        step_req1,
  output logic        step_req2,
  output logic        dir1,
  output logic        dir2,
  output logic        done
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]         dx_q, dy_q;
  logic [PERIOD_W-1:0] period_q, eff_period, tick_cnt;
  logic                ovf;
  state_t              state;

  logic [2:0]  reg_idx;
  logic        wr_en, ctrl_wr, push_req, abort, clr_ovf, pop;
  logic [31:0] fifo_rdata;
  logic        full, empty;
  logic [CW-1:0] count;

  logic [16:0] adx, ady, major_c, minor_c;
  logic        x_major_c;
  logic [16:0] major, minor, err, remaining, err_sum;
  logic        x_major;
  logic        tick;
  logic        unused_ok;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign reg_idx  = PADDR[4:2];
  assign wr_en    = PSEL && PENABLE && PWRITE;
  assign ctrl_wr  = wr_en && (reg_idx == REG_CTRL);
  assign push_req = ctrl_wr && PWDATA[CTRL_PUSH];
  assign abort    = ctrl_wr && PWDATA[CTRL_ABORT];
  assign clr_ovf  = ctrl_wr && PWDATA[CTRL_CLR_OVF];
  assign pop      = (state == ST_LOAD);

  assign unused_ok = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .push  (push_req),
    .pop   (pop),
    .flush (abort),
    .wdata ({dx_q, dy_q}),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Head-of-queue decode used in LOAD; ties go to the x axis.
  assign adx       = abs17(fifo_rdata[31:16]);
  assign ady       = abs17(fifo_rdata[15:0]);
  assign x_major_c = (adx >= ady);
  assign major_c   = x_major_c ? adx : ady;
  assign minor_c   = x_major_c ? ady : adx;

  // A period below 2 would leave no setup time for dir, so clamp it. The
  // >= compare keeps a mid-move PERIOD reduction from skipping a tick.
  assign eff_period = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;
  assign tick       = (tick_cnt >= eff_period - PERIOD_W'(1));
  assign err_sum    = err + minor;

  // Register file and overflow flag.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      dx_q     <= '0;
      dy_q     <= '0;
      period_q <= PERIOD_W'(PERIOD_RST);
      ovf      <= 1'b0;
    end else begin
      if (wr_en && reg_idx == REG_DX)     dx_q     <= PWDATA[15:0];
      if (wr_en && reg_idx == REG_DY)     dy_q     <= PWDATA[15:0];
      if (wr_en && reg_idx == REG_PERIOD) period_q <= PWDATA[PERIOD_W-1:0];
      if (clr_ovf) ovf <= 1'b0;
      // A push that coincides with a pop is accepted even when full.
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  // Sequencer: IDLE -> LOAD -> RUN -> LOAD/IDLE; strobes and dir registered.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state     <= ST_IDLE;
      step_req1 <= 1'b0;
      step_req2 <= 1'b0;
      dir1      <= 1'b0;
      dir2      <= 1'b0;
      major     <= '0;
      minor     <= '0;
      err       <= '0;
      remaining <= '0;
      x_major   <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      step_req1 <= 1'b0;
      step_req2 <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: if (!empty) state <= ST_LOAD;
          ST_LOAD: begin
            dir1      <= fifo_rdata[31];
            dir2      <= fifo_rdata[15];
            major     <= major_c;
            minor     <= minor_c;
            err       <= major_c >> 1;
            remaining <= major_c;
            x_major   <= x_major_c;
            tick_cnt  <= '0;
            if (major_c == '0) state <= (count > CW'(1)) ? ST_LOAD : ST_IDLE;
            else               state <= ST_RUN;
          end
          ST_RUN: begin
            if (tick) begin
              tick_cnt <= '0;
              if (err_sum >= major) begin
                err       <= err_sum - major;
                step_req1 <= 1'b1;
                step_req2 <= 1'b1;
              end else begin
                err       <= err_sum;
                step_req1 <= x_major;
                step_req2 <= !x_major;
              end
              remaining <= remaining - 17'd1;
              if (remaining == 17'd1) state <= empty ? ST_IDLE : ST_LOAD;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef LINE_INTERP_IRQ_EN
  logic move_end, done_q;

  // A move ends on its last tick, or in LOAD for a zero-length command; it
  // only counts as done when nothing is left queued behind it.
  always_comb begin
    move_end = 1'b0;
    if (!abort) begin
      if (state == ST_LOAD && major_c == '0 && count == CW'(1)) move_end = 1'b1;
      if (state == ST_RUN && tick && remaining == 17'd1 && empty) move_end = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) done_q <= 1'b0;
    else          done_q <= move_end;
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  // NOTE: PRDATA gets a default before the case so no path infers a latch.
  always_comb begin
    PRDATA = '0;
    unique case (reg_idx)
      REG_DX:     PRDATA = {{16{dx_q[15]}}, dx_q};
      REG_DY:     PRDATA = {{16{dy_q[15]}}, dy_q};
      REG_PERIOD: PRDATA = 32'(period_q);
      REG_STATUS: begin
        PRDATA[STAT_BUSY]                    = (state != ST_IDLE) || !empty;
        PRDATA[STAT_FULL]                    = full;
        PRDATA[STAT_OVF]                     = ovf;
        PRDATA[STAT_CNT_LSB+3:STAT_CNT_LSB]  = 4'(count);
      end
      default: PRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_line_interpolator.sv
// Self-checking bench for line_interpolator. Every command pushed to the DUT
// also pushes its expected tick sequence (strobes, dirs, spacing) into a
// scoreboard queue; a monitor pops and compares on each observed strobe.
module tb_line_interpolator;

`ifdef LINE_INTERP_IRQ_EN
  localparam int DONE_EXP = 1;
`else
  localparam int DONE_EXP = 0;
`endif

  localparam logic [31:0] A_DX = 32'h00, A_DY = 32'h04, A_PERIOD = 32'h08,
                          A_CTRL = 32'h0C, A_STATUS = 32'h10;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        step_req1, step_req2, dir1, dir2, done;

  always #5 PCLK = ~PCLK;

  line_interpolator #(.DEPTH(4), .PERIOD_W(16)) dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .step_req1 (step_req1),
    .step_req2 (step_req2),
    .dir1      (dir1),
    .dir2      (dir2),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit s1;
    bit s2;
    bit d1;
    bit d2;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   cur_period = 1000;

  // Reference Bresenham: expected strobe pattern for one command.
  task automatic push_expect(input int dx, input int dy);
    int adx, ady, maj, mn, err, s, eff;
    bit xm, mstep;
    exp_t e;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    xm  = (adx >= ady);
    maj = xm ? adx : ady;
    mn  = xm ? ady : adx;
    err = maj / 2;
    eff = (cur_period < 2) ? 2 : cur_period;
    for (int i = 0; i < maj; i++) begin
      s     = err + mn;
      mstep = (s >= maj);
      err   = mstep ? s - maj : s;
      e.s1  = xm ? 1'b1 : mstep;
      e.s2  = xm ? mstep : 1'b1;
      e.d1  = (dx < 0);
      e.d2  = (dy < 0);
      e.gap = (i == 0) ? 0 : eff;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int cyc = 0, last_cyc = 0;
  int n_s1 = 0, n_s2 = 0, n_both = 0, n_done = 0;

  always @(negedge PCLK) begin
    exp_t e;
    cyc++;
    if (done === 1'b1) n_done++;
    if (step_req1 === 1'b1 || step_req2 === 1'b1) begin
      if (step_req1) n_s1++;
      if (step_req2) n_s2++;
      if (step_req1 && step_req2) n_both++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, step_req1, step_req2}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_pattern", {28'd0, step_req1, step_req2, dir1, dir2},
              {28'd0, e.s1, e.s2, e.d1, e.d2});
        if (e.gap > 0) check("strobe_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_period(input int p);
    apb_write(A_PERIOD, p);
    cur_period = p;
  endtask

  task automatic send_cmd(input int dx, input int dy, input bit accept);
    apb_write(A_DX, dx);
    apb_write(A_DY, dy);
    if (accept) push_expect(dx, dy);
    apb_write(A_CTRL, 32'h1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge PCLK);
      k++;
    end
    check(tag, exp_q.size(), 0);
    repeat (6) @(negedge PCLK);
  endtask

  logic [31:0] rd;
  int b_s1, b_s2, b_both, b_done;

  task automatic mark();
    b_s1 = n_s1; b_s2 = n_s2; b_both = n_both; b_done = n_done;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge PCLK);
    check("rst_outputs", {27'd0, step_req1, step_req2, dir1, dir2, done}, 32'd0);
    check("rst_pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'd2);
    PRESERN = 1'b1;
    apb_read(A_PERIOD, rd); check("rst_period", rd, 32'd1000);
    apb_read(A_DX, rd);     check("rst_dx", rd, 32'd0);
    apb_read(A_DY, rd);     check("rst_dy", rd, 32'd0);
    apb_read(A_STATUS, rd); check("rst_status", rd, 32'd0);

    // (4,2) at PERIOD 10.
    set_period(10);
    mark();
    send_cmd(4, 2, 1'b1);
    wait_drain("drain_4_2", 500);
    check("s1_count_4_2", n_s1 - b_s1, 4);
    check("s2_count_4_2", n_s2 - b_s2, 2);
    check("done_4_2", n_done - b_done, DONE_EXP);
    apb_read(A_STATUS, rd); check("status_idle_4_2", rd, 32'd0);

    // (-3,5) at PERIOD 2: y is major, dir1 negative.
    set_period(2);
    mark();
    send_cmd(-3, 5, 1'b1);
    apb_read(A_DX, rd); check("dx_readback_neg", rd, 32'hFFFF_FFFD);
    wait_drain("drain_m3_5", 500);
    check("s2_count_m3_5", n_s2 - b_s2, 5);
    check("s1_count_m3_5", n_s1 - b_s1, 3);
    check("done_m3_5", n_done - b_done, DONE_EXP);

    // Overflow: 5 pushes while busy on a DEPTH=4 queue.
    set_period(30);
    mark();
    send_cmd(3, 0, 1'b1);
    send_cmd(1, 0, 1'b1);
    send_cmd(0, 1, 1'b1);
    send_cmd(1, 1, 1'b1);
    send_cmd(2, 1, 1'b1);
    send_cmd(0, 7, 1'b0);
    apb_read(A_STATUS, rd);
    check("ovf_status_word", rd, 32'h47);
    check("ovf_full_bit", rd[1], 1'b1);
    check("ovf_ovf_bit", rd[2], 1'b1);
    apb_write(A_CTRL, 32'h4);
    apb_read(A_STATUS, rd); check("ovf_cleared", rd[2], 1'b0);
    wait_drain("drain_ovf", 3000);
    repeat (250) @(negedge PCLK);
    check("ovf_s2_count", n_s2 - b_s2, 3);
    check("done_ovf", n_done - b_done, DONE_EXP);
    apb_read(A_STATUS, rd); check("status_idle_ovf", rd, 32'd0);

    // Abort after the second tick of a long move with two queued behind it.
    set_period(20);
    mark();
    send_cmd(100, 0, 1'b1);
    send_cmd(1, 1, 1'b1);
    send_cmd(2, 0, 1'b1);
    begin
      int k = 0;
      while (n_s1 - b_s1 < 2 && k < 500) begin
        @(negedge PCLK);
        k++;
      end
      check("abort_wait_2_ticks", n_s1 - b_s1, 2);
    end
    apb_write(A_CTRL, 32'h2);
    exp_q.delete();
    repeat (150) @(negedge PCLK);
    check("abort_no_more_strobes", n_s1 - b_s1, 2);
    apb_read(A_STATUS, rd);
    check("abort_count", rd[7:4], 4'd0);
    check("abort_busy", rd[0], 1'b0);
    check("abort_done", n_done - b_done, 0);

    // Asynchronous reset in the middle of a negative-x move.
    set_period(10);
    mark();
    send_cmd(-50, 0, 1'b1);
    begin
      int k = 0;
      while (n_s1 - b_s1 < 3 && k < 500) begin
        @(negedge PCLK);
        k++;
      end
      check("rst_wait_3_ticks", n_s1 - b_s1, 3);
    end
    check("dir1_before_reset", dir1, 1'b1);
    @(posedge PCLK);
    #3 PRESERN = 1'b0;
    #1 check("async_rst_outputs", {27'd0, step_req1, step_req2, dir1, dir2, done}, 32'd0);
    exp_q.delete();
    mark();
    repeat (40) @(negedge PCLK);
    check("rst_no_strobes", n_s1 - b_s1, 0);
    PRESERN = 1'b1;
    cur_period = 1000;
    apb_read(A_PERIOD, rd); check("rst_period_after", rd, 32'd1000);
    apb_read(A_STATUS, rd); check("rst_status_after", rd, 32'd0);

    // Zero-length command followed by a diagonal step, queued behind a move.
    set_period(10);
    mark();
    send_cmd(3, 0, 1'b1);
    send_cmd(0, 0, 1'b1);
    send_cmd(1, 1, 1'b1);
    wait_drain("drain_zero", 500);
    check("zero_both_count", n_both - b_both, 1);
    check("zero_s1_count", n_s1 - b_s1, 4);
    check("zero_s2_count", n_s2 - b_s2, 1);
    check("done_zero", n_done - b_done, DONE_EXP);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
